mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller, between the EX/MEM pipe register and the MEM/WB pipe register.
- Takes load/store requests from EX/MEM and runs a variable-latency req/ack handshake to the data memory.
- Drives the global pipeline stall (feeds memStall_i of all pipe registers) and returns load data to MEM/WB Read_Data_i.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, max WAIT cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- MemRead_i  in  1  load request from EX/MEM
- MemWrite_i  in  1  store request from EX/MEM
- Addr_i  in  ADDR_W  byte address (ALU result)
- WriteData_i  in  DATA_W  store data
- ReadData_o  out  DATA_W  load data to MEM/WB, registered
- memStall_o  out  1  pipeline stall, combinational
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  1 = write, registered
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched write data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- err_o  out  1  sticky timeout error

Behaviour:
- Reset (rst_i low, asynchronous) values:
  - state = IDLE
  - ReadData_o, mem_addr_o, mem_wdata_o = 0
  - mem_req_o, mem_we_o, err_o = 0
  - timeout counter = 0
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - memStall_o = MemRead_i | MemWrite_i.
  - On a request, at the edge: latch Addr_i and WriteData_i; set mem_we_o = MemWrite_i; set mem_req_o = 1; go to WAIT.
  - With no request, stay in IDLE.
- WAIT:
  - memStall_o = 1; mem_req_o and all mem_* outputs held stable.
  - On a cycle with mem_ack_i high, at the edge:
    - mem_req_o = 0.
    - If the access is a read (mem_we_o = 0), ReadData_o = mem_rdata_i.
    - Go to DONE.
- DONE:
  - memStall_o = 0 for exactly one cycle, so the pipeline advances and MEM/WB captures ReadData_o.
  - Request inputs are ignored, because they still show the completing instruction.
  - Always go to IDLE.
- Latency: ack on the first WAIT cycle gives 2 stall cycles. Each extra ack delay cycle adds 1 stall cycle.
- ReadData_o holds its value until the next read completes. Stores never modify it.
- MemRead_i and MemWrite_i both high: treated as a write.
- mem_ack_i in IDLE or DONE is ignored.
- Reset asserted mid-access (WAIT): the request drops immediately. The memory must itself be reset by the same rst_i, so no orphan ack occurs.
- The memory holds mem_req_o to ack ordering; there is no back-to-back pipelining and only one outstanding access.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter increments every WAIT cycle and clears on entry to WAIT.
  - When the count reaches TIMEOUT_CYC without an ack: mem_req_o = 0, ReadData_o = 32'hDEADBEEF for a read, err_o = 1 (sticky until reset), go to DONE.
- Undefined:
  - No counter; WAIT lasts until ack indefinitely.
  - err_o is tied 0.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, WAIT, DONE)
  - the DATA_W and ADDR_W defaults
  - the TIMEOUT_FILL constant (32'hDEADBEEF)
- One natural sub-module, mem_timeout_cnt: a loadable saturating counter with a clear input and a terminal-count output, instantiated only under MEM_TIMEOUT_EN.
- The FSM and datapath latches stay in the top module.

Test Plan:
- Reset mid-operation: rst_i low at cycle 5 while in WAIT -> outputs zero immediately; state IDLE; no stall after release.
- Load, ack 1 cycle after req: MemRead_i = 1, Addr_i = 0x100, mem_rdata_i = 0x12345678 -> 2 stall cycles; ReadData_o = 0x12345678 in DONE; memStall_o low in DONE.
- Store, ack delayed 4 cycles: MemWrite_i = 1, Addr_i = 0x40, WriteData_i = 0xCAFEF00D -> mem_we_o = 1 and mem_wdata_o = 0xCAFEF00D held through WAIT; 5 stall cycles; ReadData_o unchanged.
- Back-to-back load then store: the second request is not launched in DONE; it starts in the following IDLE cycle; mem_req_o is low for exactly 2 cycles between the accesses.
- Spurious mem_ack_i in IDLE and DONE -> no state change; ReadData_o unchanged.
- MEM_TIMEOUT_EN with TIMEOUT_CYC = 8, no ack -> abort after 8 WAIT cycles; ReadData_o = 0xDEADBEEF; err_o = 1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state type and constants for the MEM-stage access unit
package mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Load data returned when an access is abandoned without an ack
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - loadable saturating counter with clear and terminal-count flag
module mem_timeout_cnt #(
    parameter int unsigned      CNT_W  = 8,
    parameter logic [CNT_W-1:0] TC_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store req/ack controller; MEM_TIMEOUT_EN adds a WAIT abort
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WriteData_i,
    output logic [DATA_W-1:0] ReadData_o,
    output logic              memStall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    mem_state_e        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              start;
    logic              timeout_hit;

    assign start = (state_q == IDLE) && (MemRead_i || MemWrite_i);

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        req_d      = req_q;
        we_d       = we_q;
        memStall_o = 1'b0;
        case (state_q)
            IDLE: begin
                memStall_o = MemRead_i || MemWrite_i;
                if (start) begin
                    addr_d  = Addr_i;
                    wdata_d = WriteData_i;
                    we_d    = MemWrite_i;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                memStall_o = 1'b1;
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = DATA_W'(TIMEOUT_FILL);
                    end
                end
            end
            // Request inputs still show the finishing instruction here, so they are ignored
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
        end
    end

    assign ReadData_o  = rdata_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic cnt_tc;
    logic err_q, err_d;

    // Terminal count one below the limit so the abort lands on the edge ending WAIT cycle TIMEOUT_CYC
    mem_timeout_cnt #(
        .CNT_W  (CNT_W),
        .TC_VAL (CNT_W'(TIMEOUT_CYC - 1))
    ) u_timeout_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_i),
        .clr_i      (start),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (state_q == WAIT),
        .tc_o       (cnt_tc)
    );

    assign timeout_hit = (state_q == WAIT) && !mem_ack_i && cnt_tc;
    assign err_d       = err_q || timeout_hit;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

endmodule
